axi_lite_cmd_master: RTL and testbench

//  AXI4-Lite initiator: turns single register commands (write/read) from a local

---
 rtl/axi_lite_cmd_master_pkg.sv | 22 ++
 rtl/axi_lite_cmd_master.sv | 221 ++++++++++++++++++++++
 tb/tb_axi_lite_cmd_master.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_cmd_master_pkg.sv
// Shared definitions for the AXI4-Lite command master: response codes,
// protection default and FSM state encoding.
package axi_lite_cmd_master_pkg;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [1:0] RESP_DECERR  = 2'b11;
  // A timed-out transaction reports the same code as a decode error
  localparam logic [1:0] RESP_TIMEOUT = RESP_DECERR;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_WR_B  = 3'd2,
    ST_RD_AR = 3'd3,
    ST_RD_R  = 3'd4,
    ST_RSP   = 3'd5
  } state_e;

endpackage

// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite initiator: one register command in, one AXI4-Lite transaction out,
// one response back. Every output is a flop; a hung slave is cut off by a timeout.
module axi_lite_cmd_master
  import axi_lite_cmd_master_pkg::*;
#(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 5,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESETN,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic                              rsp_timeout,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int unsigned AW    = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned DW    = C_M_AXI_DATA_WIDTH;
  localparam int unsigned SW    = C_M_AXI_DATA_WIDTH / 8;
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             busy, tmo_hit, aw_done, w_done, cmd_hs;

  logic          cmd_ready_d, rsp_valid_d, rsp_timeout_d;
  logic [DW-1:0] rsp_rdata_d, wdata_d;
  logic [1:0]    rsp_resp_d;
  logic [AW-1:0] awaddr_d, araddr_d;
  logic [SW-1:0] wstrb_d;
  logic          awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;

  assign M_AXI_AWPROT = PROT_DEFAULT;
  assign M_AXI_ARPROT = PROT_DEFAULT;

  assign busy    = (state_q == ST_WR) || (state_q == ST_WR_B) ||
                   (state_q == ST_RD_AR) || (state_q == ST_RD_R);
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && busy && (tmo_cnt_q == TMO_LAST);
  // A channel counts as done once its VALID has dropped or is handshaking now
  assign aw_done = !M_AXI_AWVALID || M_AXI_AWREADY;
  assign w_done  = !M_AXI_WVALID || M_AXI_WREADY;
  assign cmd_hs  = cmd_valid && cmd_ready;

  // State register and saturating timeout counter
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q   <= ST_IDLE;
      tmo_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (!busy)
        tmo_cnt_q <= '0;
      else if (tmo_cnt_q != CNT_MAX)
        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cmd_hs) state_d = cmd_write ? ST_WR : ST_RD_AR;
      ST_WR:    if (aw_done && w_done) state_d = ST_WR_B;
      ST_WR_B:  if (M_AXI_BVALID && M_AXI_BREADY) state_d = ST_RSP;
      ST_RD_AR: if (M_AXI_ARVALID && M_AXI_ARREADY) state_d = ST_RD_R;
      ST_RD_R:  if (M_AXI_RVALID && M_AXI_RREADY) state_d = ST_RSP;
      ST_RSP:   if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (tmo_hit) state_d = ST_RSP;
  end

  // Next values of the registered outputs
  always_comb begin
    cmd_ready_d   = cmd_ready;
    rsp_valid_d   = rsp_valid;
    rsp_rdata_d   = rsp_rdata;
    rsp_resp_d    = rsp_resp;
    rsp_timeout_d = rsp_timeout;
    awaddr_d      = M_AXI_AWADDR;
    wdata_d       = M_AXI_WDATA;
    wstrb_d       = M_AXI_WSTRB;
    araddr_d      = M_AXI_ARADDR;
    awvalid_d     = M_AXI_AWVALID;
    wvalid_d      = M_AXI_WVALID;
    bready_d      = M_AXI_BREADY;
    arvalid_d     = M_AXI_ARVALID;
    rready_d      = M_AXI_RREADY;
    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_hs) begin
          cmd_ready_d = 1'b0;
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
          end
        end
      end
      ST_WR: begin
        if (M_AXI_AWREADY) awvalid_d = 1'b0;
        if (M_AXI_WREADY)  wvalid_d  = 1'b0;
        if (aw_done && w_done) bready_d = 1'b1;
      end
      ST_WR_B: begin
        if (M_AXI_BVALID && M_AXI_BREADY) begin
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_resp_d    = M_AXI_BRESP;
          rsp_timeout_d = 1'b0;
        end
      end
      ST_RD_AR: begin
        if (M_AXI_ARVALID && M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      ST_RD_R: begin
        if (M_AXI_RVALID && M_AXI_RREADY) begin
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = M_AXI_RDATA;
          rsp_resp_d    = M_AXI_RRESP;
          rsp_timeout_d = 1'b0;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: ;
    endcase
    // Hung slave: abandon every channel and report the timeout
    if (tmo_hit) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_rdata_d   = '0;
      rsp_resp_d    = RESP_TIMEOUT;
      rsp_timeout_d = 1'b1;
    end
  end

  // Output registers
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= '0;
      rsp_timeout   <= 1'b0;
      M_AXI_AWADDR  <= '0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      M_AXI_ARADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
      cmd_ready     <= cmd_ready_d;
      rsp_valid     <= rsp_valid_d;
      rsp_rdata     <= rsp_rdata_d;
      rsp_resp      <= rsp_resp_d;
      rsp_timeout   <= rsp_timeout_d;
      M_AXI_AWADDR  <= awaddr_d;
      M_AXI_WDATA   <= wdata_d;
      M_AXI_WSTRB   <= wstrb_d;
      M_AXI_ARADDR  <= araddr_d;
      M_AXI_AWVALID <= awvalid_d;
      M_AXI_WVALID  <= wvalid_d;
      M_AXI_BREADY  <= bready_d;
      M_AXI_ARVALID <= arvalid_d;
      M_AXI_RREADY  <= rready_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: behavioural AXI4-Lite slave with programmable
// ready/response delays, protocol monitor and a word-array reference model.
module tb_axi_lite_cmd_master;

  localparam int unsigned AW  = 5;
  localparam int unsigned DW  = 32;
  localparam int unsigned SW  = 4;
  localparam int unsigned TMO = 16;

  logic          clk, rst_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic [1:0]    bresp, rresp;

  int checks = 0;
  int errors = 0;

  axi_lite_cmd_master #(
    .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
    .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr),
    .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural slave ----------------
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  bit slverr_en = 1'b0;
  int aw_wait, w_wait, b_wait, ar_wait, r_wait;
  bit aw_got, w_got, ar_got;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic [DW-1:0] s_wdata;
  logic [SW-1:0] s_wstrb;
  logic [DW-1:0] smem [8];

  assign awready = awvalid && (aw_wait >= aw_dly);
  assign wready  = wvalid && (w_wait >= w_dly);
  assign arready = arvalid && (ar_wait >= ar_dly);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0; r_wait <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
      bvalid <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rresp <= 2'b00; rdata <= '0;
      s_awaddr <= '0; s_araddr <= '0; s_wdata <= '0; s_wstrb <= '0;
      for (int i = 0; i < 8; i++) smem[i] <= '0;
    end else begin
      aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
      w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
      ar_wait <= (arvalid && !arready) ? ar_wait + 1 : 0;
      if (awvalid && awready) begin aw_got <= 1'b1; s_awaddr <= awaddr; end
      if (wvalid && wready) begin w_got <= 1'b1; s_wdata <= wdata; s_wstrb <= wstrb; end
      if (arvalid && arready) begin ar_got <= 1'b1; s_araddr <= araddr; end
      if (aw_got && w_got && !bvalid) begin
        if (b_wait >= b_dly) begin
          bvalid <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0; b_wait <= 0;
          if (slverr_en && s_awaddr == 5'h1C) bresp <= 2'b10;
          else begin
            bresp <= 2'b00;
            for (int b = 0; b < 4; b++)
              if (s_wstrb[b]) smem[s_awaddr[4:2]][8*b +: 8] <= s_wdata[8*b +: 8];
          end
        end else b_wait <= b_wait + 1;
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (ar_got && !rvalid) begin
        if (r_wait >= r_dly) begin
          rvalid <= 1'b1; ar_got <= 1'b0; r_wait <= 0;
          rdata <= smem[s_araddr[4:2]]; rresp <= 2'b00;
        end else r_wait <= r_wait + 1;
      end
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  // ---------------- protocol monitor ----------------
  int cyc, aw_hs_cyc, w_hs_cyc, b_count, r_count, ar_hi_cnt, prot_err;
  bit aw_stall_q, w_stall_q, ar_stall_q, aw_hs_q, w_hs_q, ar_hs_q;
  logic [AW-1:0] aw_addr_q, ar_addr_q;
  logic [DW-1:0] w_data_q;
  logic [SW-1:0] w_strb_q;

  always @(posedge clk) begin
    bit v;
    v = 1'b0;
    cyc <= cyc + 1;
    if (rst_n) begin
      if (awvalid && awready) aw_hs_cyc <= cyc;
      if (wvalid && wready) w_hs_cyc <= cyc;
      if (bvalid && bready) b_count <= b_count + 1;
      if (rvalid && rready) r_count <= r_count + 1;
      if (arvalid) ar_hi_cnt <= ar_hi_cnt + 1;
      if (aw_stall_q && (!awvalid || awaddr !== aw_addr_q)) v = 1'b1;
      if (w_stall_q && (!wvalid || wdata !== w_data_q || wstrb !== w_strb_q)) v = 1'b1;
      if (ar_stall_q && arvalid && araddr !== ar_addr_q) v = 1'b1;
      if ((aw_hs_q && awvalid) || (w_hs_q && wvalid) || (ar_hs_q && arvalid)) v = 1'b1;
      if (bready && (awvalid || wvalid)) v = 1'b1;
      if (rready && arvalid) v = 1'b1;
      if (v) prot_err <= prot_err + 1;
    end
    aw_stall_q <= rst_n && awvalid && !awready;
    w_stall_q  <= rst_n && wvalid && !wready;
    ar_stall_q <= rst_n && arvalid && !arready;
    aw_hs_q    <= rst_n && awvalid && awready;
    w_hs_q     <= rst_n && wvalid && wready;
    ar_hs_q    <= rst_n && arvalid && arready;
    aw_addr_q  <= awaddr;
    ar_addr_q  <= araddr;
    w_data_q   <= wdata;
    w_strb_q   <= wstrb;
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] ref_mem [8];

  task automatic ref_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) ref_mem[a[4:2]][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic set_delays(input int aw, input int w, input int b, input int ar, input int r);
    aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
  endtask

  // Issue one command from a negedge; returns at a negedge with the response fields
  task automatic do_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, input bit auto_rsp,
                        output logic [DW-1:0] rd, output logic [1:0] rr, output logic to);
    int n;
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (n >= 50) begin errors++; $display("FAIL cmd_accept_wait cmd_ready=%b after %0d cycles", cmd_ready, n); end
    @(negedge clk);
    cmd_valid = 1'b0;
    if (auto_rsp) rsp_ready = 1'b1;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    checks++;
    if (n >= 60) begin errors++; $display("FAIL rsp_wait rsp_valid=%b after %0d cycles", rsp_valid, n); end
    rd = rsp_rdata; rr = rsp_resp; to = rsp_timeout;
    if (auto_rsp) begin @(negedge clk); rsp_ready = 1'b0; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid} !== 6'b0) begin
      errors++; $display("FAIL reset_handshakes got=%b exp=000000", {awvalid, wvalid, bready, arvalid, rready, rsp_valid});
    end
    checks++;
    if ({awaddr, araddr, wdata, wstrb, awprot, arprot, rsp_rdata, rsp_resp, rsp_timeout} !== '0) begin
      errors++; $display("FAIL reset_fields awaddr=%h araddr=%h wdata=%h wstrb=%h rdata=%h resp=%b to=%b",
                         awaddr, araddr, wdata, wstrb, rsp_rdata, rsp_resp, rsp_timeout);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_basic_write_read();
    logic [DW-1:0] rd; logic [1:0] rr; logic to;
    set_delays(0, 0, 0, 0, 0);
    do_cmd(1'b1, 5'h14, 32'h0000ABCD, 4'b0011, 1'b1, rd, rr, to);
    ref_write(5'h14, 32'h0000ABCD, 4'b0011);
    checks++;
    if (rr !== 2'b00 || to !== 1'b0 || rd !== '0) begin
      errors++; $display("FAIL basic_write_rsp resp=%b to=%b rdata=%h exp resp=00 to=0 rdata=0", rr, to, rd);
    end
    do_cmd(1'b0, 5'h14, '0, '0, 1'b1, rd, rr, to);
    checks++;
    if (rd !== ref_mem[5] || rr !== 2'b00 || to !== 1'b0) begin
      errors++; $display("FAIL basic_read rdata=%h resp=%b to=%b exp rdata=%h resp=00 to=0", rd, rr, to, ref_mem[5]);
    end
  endtask

  task automatic test_aw_delay();
    logic [DW-1:0] rd; logic [1:0] rr; logic to;
    int b0, pe0;
    logic [DW-1:0] d;
    d = $urandom;
    b0 = b_count; pe0 = prot_err;
    set_delays(3, 0, 0, 0, 0);
    do_cmd(1'b1, 5'h08, d, 4'hF, 1'b1, rd, rr, to);
    ref_write(5'h08, d, 4'hF);
    checks++;
    if (aw_hs_cyc - w_hs_cyc !== 3) begin
      errors++; $display("FAIL aw_delay_order aw_hs-w_hs=%0d exp=3", aw_hs_cyc - w_hs_cyc);
    end
    checks++;
    if (b_count - b0 !== 1) begin errors++; $display("FAIL aw_delay_b_count got=%0d exp=1", b_count - b0); end
    checks++;
    if (prot_err !== pe0) begin errors++; $display("FAIL aw_delay_protocol violations=%0d exp=0", prot_err - pe0); end
    checks++;
    if (rr !== 2'b00) begin errors++; $display("FAIL aw_delay_resp got=%b exp=00", rr); end
    set_delays(0, 0, 0, 0, 0);
    do_cmd(1'b0, 5'h08, '0, '0, 1'b1, rd, rr, to);
    checks++;
    if (rd !== ref_mem[2]) begin errors++; $display("FAIL aw_delay_readback got=%h exp=%h", rd, ref_mem[2]); end
  endtask

  task automatic test_slverr();
    logic [DW-1:0] rd; logic [1:0] rr; logic to;
    slverr_en = 1'b1;
    do_cmd(1'b1, 5'h1C, 32'h12345678, 4'hF, 1'b1, rd, rr, to);
    slverr_en = 1'b0;
    checks++;
    if (rr !== 2'b10 || to !== 1'b0) begin
      errors++; $display("FAIL slverr_rsp resp=%b to=%b exp resp=10 to=0", rr, to);
    end
    do_cmd(1'b0, 5'h1C, '0, '0, 1'b1, rd, rr, to);
    checks++;
    if (rd !== ref_mem[7] || rr !== 2'b00) begin
      errors++; $display("FAIL slverr_readback rdata=%h resp=%b exp rdata=%h resp=00", rd, rr, ref_mem[7]);
    end
  endtask

  task automatic test_rsp_backpressure();
    logic [DW-1:0] rd; logic [1:0] rr; logic to;
    do_cmd(1'b0, 5'h14, '0, '0, 1'b0, rd, rr, to);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== ref_mem[5] || cmd_ready !== 1'b0) begin
        errors++; $display("FAIL backpressure_hold cyc=%0d valid=%b rdata=%h cmd_ready=%b exp 1/%h/0",
                           i, rsp_valid, rsp_rdata, cmd_ready, ref_mem[5]);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL backpressure_release valid=%b cmd_ready=%b exp 0/1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_random_traffic();
    logic [DW-1:0] rd, d, exp_rd; logic [1:0] rr; logic to;
    logic [AW-1:0] a; logic [SW-1:0] s; logic wr;
    int b0, r0, pe0, nw, nr;
    b0 = b_count; r0 = r_count; pe0 = prot_err; nw = 0; nr = 0;
    for (int i = 0; i < 30; i++) begin
      set_delays(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      a = {3'($urandom_range(0, 6)), 2'b00};
      d = $urandom; s = 4'($urandom_range(0, 15)); wr = 1'($urandom_range(0, 1));
      do_cmd(wr, a, d, s, 1'b1, rd, rr, to);
      if (wr) begin ref_write(a, d, s); exp_rd = '0; nw++; end
      else begin exp_rd = ref_mem[a[4:2]]; nr++; end
      checks++;
      if (rd !== exp_rd || rr !== 2'b00 || to !== 1'b0) begin
        errors++; $display("FAIL random_%0d wr=%b addr=%h rdata=%h resp=%b to=%b exp rdata=%h resp=00 to=0",
                           i, wr, a, rd, rr, to, exp_rd);
      end
    end
    checks++;
    if (b_count - b0 !== nw || r_count - r0 !== nr) begin
      errors++; $display("FAIL random_counts b=%0d r=%0d exp b=%0d r=%0d", b_count - b0, r_count - r0, nw, nr);
    end
    checks++;
    if (prot_err !== pe0) begin errors++; $display("FAIL random_protocol violations=%0d exp=0", prot_err - pe0); end
    set_delays(0, 0, 0, 0, 0);
  endtask

  task automatic test_timeout();
    logic [DW-1:0] rd; logic [1:0] rr; logic to;
    int a0;
    set_delays(0, 0, 0, 100000, 0);
    a0 = ar_hi_cnt;
    do_cmd(1'b0, 5'h04, '0, '0, 1'b0, rd, rr, to);
    checks++;
    if (ar_hi_cnt - a0 !== int'(TMO)) begin
      errors++; $display("FAIL timeout_arvalid_cycles got=%0d exp=%0d", ar_hi_cnt - a0, TMO);
    end
    checks++;
    if (rr !== 2'b11 || to !== 1'b1) begin
      errors++; $display("FAIL timeout_rsp resp=%b to=%b exp resp=11 to=1", rr, to);
    end
    checks++;
    if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin
      errors++; $display("FAIL timeout_drop got=%b exp=00000", {awvalid, wvalid, bready, arvalid, rready});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    set_delays(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_read();
    logic [DW-1:0] rd; logic [1:0] rr; logic to;
    int n; bit seen;
    set_delays(0, 0, 0, 0, 10);
    cmd_write = 1'b0; cmd_addr = 5'h14; cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (rready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n >= 20) begin errors++; $display("FAIL midreset_reach_rd_r rready=%b after %0d cycles", rready, n); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready} !== 7'b0) begin
      errors++; $display("FAIL midreset_async got=%b exp=0000000",
                         {awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready});
    end
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin @(negedge clk); if (rsp_valid !== 1'b0) seen = 1'b1; end
    checks++;
    if (seen) begin errors++; $display("FAIL midreset_no_rsp rsp_valid seen=1 exp=0"); end
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL midreset_cmd_ready got=%b exp=1", cmd_ready); end
    set_delays(0, 0, 0, 0, 0);
    do_cmd(1'b0, 5'h14, '0, '0, 1'b1, rd, rr, to);
    checks++;
    if (rd !== ref_mem[5] || rr !== 2'b00) begin
      errors++; $display("FAIL midreset_readback rdata=%h resp=%b exp rdata=%h resp=00", rd, rr, ref_mem[5]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_write_read();
    test_aw_delay();
    test_slverr();
    test_rsp_backpressure();
    test_random_traffic();
    test_timeout();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
